// File: rtl/lum_norm_if.sv
// lum_norm_if: pixel-in / luminance-out streaming bundle for lum_norm.
//   in_valid/in_ready       : upstream handshake
//   in_r/in_g/in_b          : 8-bit unsigned sRGB components
//   out_valid/out_ready     : downstream handshake
//   out_lum                 : normalised luminance, unsigned 1.8 (LUM_OUT bits)
//   out_eol/out_eof         : last pixel of line / last pixel of frame
// master = the side feeding pixels and consuming luminance; slave = lum_norm.
interface lum_norm_if #(
    parameter int LUM_OUT = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_r;
    logic [7:0]         in_g;
    logic [7:0]         in_b;
    logic               out_valid;
    logic               out_ready;
    logic [LUM_OUT-1:0] out_lum;
    logic               out_eol;
    logic               out_eof;

    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_lum, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_lum, out_eol, out_eof
    );
endinterface

// File: rtl/lum_norm.sv
// lum_norm: RGB to normalised luminance, 2-stage elastic pipeline.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lum_norm_if.slave (pixel input handshake, luminance output handshake)
// Y = (77R + 150G + 29B + 128) >> 8, out_lum = Y + Y[7] so that 255 -> 1.0.
// Each accepted pixel is tagged with end-of-line / end-of-frame from the
// internal column/row counters.
module lum_norm #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int LUM_OUT = 9
) (
    input logic     clk,
    input logic     rst_n,
    lum_norm_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    function automatic logic [15:0] weighted_sum(input logic [7:0] r, input logic [7:0] g,
                                                 input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'(r) * 16'd77 + 16'(g) * 16'd150 + 16'(b) * 16'd29;
        return acc;
    endfunction

    // Max sum is 65280, so adding the half-LSB cannot wrap 16 bits.
    function automatic logic [8:0] round_norm(input logic [15:0] sum);
        logic [15:0] rnd;
        logic [7:0]  y;
        rnd = sum + 16'd128;
        y   = rnd[15:8];
        return {1'b0, y} + {8'd0, y[7]};
    endfunction

    logic               adv_p1, adv_p2, accept;
    logic               vld_p1, vld_p2;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               at_eol, at_eof;

    logic [15:0]        sum_p1;
    logic               eol_p1, eof_p1;
    logic [LUM_OUT-1:0] lum_p2;
    logic               eol_p2, eof_p2;

    assign adv_p2 = !vld_p2 || bus.out_ready;
    assign adv_p1 = !vld_p1 || adv_p2;
    assign accept = bus.in_valid && adv_p1;
    assign at_eol = (col == COL_W'(IMG_W - 1));
    assign at_eof = at_eol && (row == ROW_W'(IMG_H - 1));

    assign bus.in_ready  = adv_p1;
    assign bus.out_valid = vld_p2;
    assign bus.out_lum   = lum_p2;
    assign bus.out_eol   = eol_p2;
    assign bus.out_eof   = eof_p2;

    // Position counters: move only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (at_eof) begin
                col <= '0;
                row <= '0;
            end else if (at_eol) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage p1: weighted sum and position flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sum_p1 <= weighted_sum(bus.in_r, bus.in_g, bus.in_b);
            eol_p1 <= at_eol;
            eof_p1 <= at_eof;
        end
    end

    // Stage p2: normalised luminance and flags, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            lum_p2 <= '0;
            eol_p2 <= 1'b0;
            eof_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                lum_p2 <= LUM_OUT'(round_norm(sum_p1));
                eol_p2 <= eol_p1;
                eof_p2 <= eof_p1;
            end
        end
    end
endmodule

// File: doc/lum_norm.md
LUM_NORM -- requirements
Module: lum_norm

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line (2..4096).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (2..4096).
REQ-003 SHALL have parameter LUM_OUT, default 9, meaning output luminance width in unsigned 1.8 fixed point; 9'b1_00000000 = 1.0.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream pixel beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-008 SHALL have ports in_r, in_g, in_b  input  8 each  unsigned sRGB pixel components.
REQ-009 SHALL have port out_valid  output  1  out_lum beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream tone-mapping stage accepts the beat.
REQ-011 SHALL have port out_lum  output  LUM_OUT  normalised luminance, unsigned 1.8.
REQ-012 SHALL have port out_eol  output  1  beat is the last pixel of a line.
REQ-013 SHALL have port out_eof  output  1  beat is the last pixel of a frame.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready, and transfer a beat when out_valid && out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers the weighted sum and position flags; S2 registers out_lum, out_eol and out_eof.
REQ-016 SHALL advance S2 when !out_valid || out_ready, and S1 when S1 is empty or S2 advances. in_ready SHALL equal the S1 advance condition and SHALL be combinational from out_ready and the stage valids.
REQ-017 SHALL give a latency of exactly 2 cycles from an accepted beat to out_valid when out_ready is held high, and SHALL sustain 1 beat per cycle.
REQ-018 SHALL compute sum = 77*R + 150*G + 29*B in 16 unsigned bits. The maximum value is 65280, so no overflow occurs.
REQ-019 SHALL compute Y = (sum + 128) >> 8, an 8-bit value in the range 0..255.
REQ-020 SHALL output out_lum = Y + Y[7] in 9 bits, so 255 maps to 256 (1.0), 128 maps to 129, 127 maps to 127, and 0 maps to 0.
REQ-021 SHALL keep out_lum, out_eol and out_eof stable while out_valid && !out_ready.
REQ-022 SHALL count accepted beats with a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), and SHALL tag each beat with eol = (col == IMG_W-1) and eof = eol && (row == IMG_H-1) at acceptance.
REQ-023 SHALL wrap the column to 0 on eol and increment the row. It SHALL wrap both counters to 0 on eof, so the next beat is pixel (0,0) of a new frame.
REQ-024 SHALL advance the counters only on accepted beats; stalls and bubbles do not alter the counters.
REQ-025 SHALL never drop or duplicate a beat under any out_ready pattern, including out_ready toggling every cycle.
REQ-026 SHALL ignore in_r, in_g and in_b when the beat is not accepted.

Reset
REQ-027 SHALL, while rst_n = 0, force out_valid = 0, out_lum = 0, out_eol = 0, out_eof = 0, clear all stage valids, and set the column and row counters to 0.
REQ-028 SHALL discard in-flight beats on reset asserted mid-frame. After release, the first accepted beat SHALL be pixel (0,0).
REQ-029 SHALL drive in_ready = 1 on the first cycle after reset release.

Verification
REQ-030 SHALL pass this test: beats (255,255,255), (0,0,0), (128,128,128), (255,0,0) with out_ready = 1 -> out_lum = 256, 0, 129, 77, each 2 cycles after its accept.
REQ-031 SHALL pass this test: IMG_W = 4, IMG_H = 2, 8 continuous beats -> out_eol on beats 4 and 8, out_eof only on beat 8, and beat 9 has no flags.
REQ-032 SHALL pass this test: out_ready = 0 for 5 cycles with in_valid = 1 -> exactly 2 beats are absorbed, then in_ready = 0 and out_lum is held. On release, the output order is intact with no loss.
REQ-033 SHALL pass this test: random in_valid and out_ready at 50% each over 10k beats -> the output stream matches the reference model exactly, with flags correct.
REQ-034 SHALL pass this test: rst_n pulsed low at beat 3 of a line -> outputs are zero within the same cycle, and the next frame's first eol falls on beat IMG_W.
REQ-035 SHALL pass this test: (0,255,0) and (0,0,255) -> out_lum = 150 and 29 respectively.
